// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU controller: walks an external 1-bit slice LSB-first over WIDTH cycles.
// Define SERIAL_ALU_OVF_EN to add the signed Overflow output.
module serial_alu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  output logic [1:0]       SliceSel,
  output logic             SliceA,
  output logic             SliceB,
  output logic             SliceInvertB,
  output logic             SliceCin,
  input  logic             SliceOut,
  input  logic             SliceCout,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Zero,
`ifdef SERIAL_ALU_OVF_EN
  output logic             Overflow,
`endif
  output logic [1:0]       state_dbg
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, work, res_nxt;
  logic [1:0]       op_q;
  logic [IW-1:0]    idx;
  logic             carry_q;
  logic             last_bit, arith;

  assign last_bit  = (idx == IW'(WIDTH - 1));
  assign arith     = op_q[1];
  assign Busy      = (state == RUN);
  assign Done      = (state == DONE);
  assign state_dbg = state;

  // Handshake: Start is a request that is accepted only at an edge in IDLE (no
  // queueing); Done is a one-cycle pulse, and Result/flags stay valid until the next Done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    SliceSel     = 2'b00;
    SliceA       = 1'b0;
    SliceB       = 1'b0;
    SliceInvertB = 1'b0;
    SliceCin     = 1'b0;
    if (state == RUN) begin
      SliceSel     = arith ? 2'b10 : {1'b0, op_q[0]};
      SliceA       = a_q[idx];
      SliceB       = b_q[idx];
      SliceInvertB = (op_q == 2'b11);
      SliceCin     = (idx == '0) ? (op_q == 2'b11) : carry_q;
    end
  end

  // Partial result with the current slice bit merged in; becomes Result on the last bit.
  always_comb begin
    res_nxt      = work;
    res_nxt[idx] = SliceOut;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 2'b00;
      idx      <= '0;
      carry_q  <= 1'b0;
      work     <= '0;
      Result   <= '0;
      CarryOut <= 1'b0;
      Zero     <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
      Overflow <= 1'b0;
`endif
    end else begin
      if (state == IDLE && Start) begin
        a_q     <= DataA;
        b_q     <= DataB;
        op_q    <= Op;
        idx     <= '0;
        carry_q <= 1'b0;
      end else if (state == RUN) begin
        work    <= res_nxt;
        carry_q <= SliceCout;
        idx     <= idx + 1'b1;
        if (last_bit) begin
          Result   <= res_nxt;
          CarryOut <= arith & SliceCout;
          Zero     <= (res_nxt == '0);
`ifdef SERIAL_ALU_OVF_EN
          Overflow <= arith & (SliceCin ^ SliceCout);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Randomized self-checking bench for serial_alu_ctrl with a behavioural 1-bit slice and
// an arithmetic reference model; checks Overflow too when SERIAL_ALU_OVF_EN is defined.
module tb_serial_alu_ctrl;
  localparam int WIDTH = 32;

  logic             clk, rst, Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] DataA, DataB;
  logic [1:0]       SliceSel;
  logic             SliceA, SliceB, SliceInvertB, SliceCin;
  logic             SliceOut, SliceCout;
  logic             Busy, Done;
  logic [WIDTH-1:0] Result;
  logic             CarryOut, Zero;
`ifdef SERIAL_ALU_OVF_EN
  logic             Overflow;
`endif
  logic [1:0]       state_dbg;

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [2:0]       flag_q[$];

  serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Op(Op), .DataA(DataA), .DataB(DataB),
    .SliceSel(SliceSel), .SliceA(SliceA), .SliceB(SliceB),
    .SliceInvertB(SliceInvertB), .SliceCin(SliceCin),
    .SliceOut(SliceOut), .SliceCout(SliceCout),
    .Busy(Busy), .Done(Done), .Result(Result), .CarryOut(CarryOut), .Zero(Zero),
`ifdef SERIAL_ALU_OVF_EN
    .Overflow(Overflow),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-bit slice; logic ops drive a junk carry so the controller must mask it
  logic b_eff;
  always_comb begin
    b_eff     = SliceB ^ SliceInvertB;
    SliceOut  = 1'b0;
    SliceCout = 1'b0;
    case (SliceSel)
      2'b00: begin SliceOut = SliceA & SliceB; SliceCout = SliceA ^ SliceB; end
      2'b01: begin SliceOut = SliceA | SliceB; SliceCout = SliceA ^ SliceB; end
      2'b10: begin
        SliceOut  = SliceA ^ b_eff ^ SliceCin;
        SliceCout = (SliceA & b_eff) | (SliceA & SliceCin) | (b_eff & SliceCin);
      end
      default: ;
    endcase
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: plain two's-complement arithmetic; flags = {carry, zero, overflow}
  task automatic model(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       output logic [WIDTH-1:0] res, output logic [2:0] flags);
    logic [WIDTH:0] s;
    logic c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (op)
      2'b00: res = a & b;
      2'b01: res = a | b;
      2'b10: begin
        s = {1'b0, a} + {1'b0, b};
        res = s[WIDTH-1:0]; c = s[WIDTH];
        v = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      default: begin
        s = {1'b0, a} + {1'b0, ~b} + 1;
        res = s[WIDTH-1:0]; c = s[WIDTH];
        v = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
    endcase
    flags = {c, (res == '0), v};
  endtask

  // driver: one operation; optional rst release on the Start cycle, optional Start held through RUN
  task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input bit hold_start, input bit rel_rst);
    logic [WIDTH-1:0] er, er_hold;
    logic [2:0]       ef;
    int  cyc, busy_n;
    bit  seen;
    @(negedge clk);
    if (rel_rst) rst = 1'b0;
    Start = 1'b1; Op = op; DataA = a; DataB = b;
    model(op, a, b, er, ef);
    exp_q.push_back(er);
    flag_q.push_back(ef);
    @(posedge clk);
    cyc = 0; busy_n = 0; seen = 0;
    while (!seen && cyc < WIDTH + 10) begin
      @(negedge clk);
      cyc++;
      if (hold_start) begin
        Op = 2'($urandom_range(0, 3)); DataA = $urandom; DataB = $urandom;
      end else begin
        Start = 1'b0;
      end
      if (Busy) begin
        busy_n++;
        if (cyc <= WIDTH) begin
          check_val("slice_a", SliceA, a[cyc-1]);
          check_val("slice_b", SliceB, b[cyc-1]);
          check_val("slice_sel", SliceSel, op[1] ? 2'b10 : {1'b0, op[0]});
          check_val("slice_inv", SliceInvertB, op == 2'b11);
        end
        if (cyc == 1) check_val("slice_cin0", SliceCin, op == 2'b11);
      end
      if (Done) seen = 1;
    end
    check_val("done_seen", seen, 1);
    check_val("latency", cyc, WIDTH + 1);
    check_val("busy_cycles", busy_n, WIDTH);
    er_hold = '0;
    if (seen && exp_q.size() > 0) begin
      er = exp_q.pop_front();
      ef = flag_q.pop_front();
      er_hold = er;
      check_val("result", Result, er);
      check_val("carry_out", CarryOut, ef[2]);
      check_val("zero", Zero, ef[1]);
`ifdef SERIAL_ALU_OVF_EN
      check_val("overflow", Overflow, ef[0]);
`endif
    end
    Start = 1'b0;
    @(negedge clk);
    check_val("done_pulse", Done, 0);
    check_val("no_requeue", Busy, 0);
    check_val("idle_slice", {SliceSel, SliceA, SliceB, SliceInvertB, SliceCin}, 0);
    check_val("result_hold", Result, er_hold);
  endtask

  initial begin
    logic [1:0] rop;
    Start = 1'b0; Op = 2'b00; DataA = '0; DataB = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst_busy", Busy, 0);
    check_val("rst_done", Done, 0);
    check_val("rst_result", Result, 0);
    check_val("rst_flags", {CarryOut, Zero}, 0);
    check_val("rst_state", state_dbg, 0);
    check_val("rst_slice", {SliceSel, SliceA, SliceB, SliceInvertB, SliceCin}, 0);
`ifdef SERIAL_ALU_OVF_EN
    check_val("rst_ovf", Overflow, 0);
`endif
    rst = 1'b0;

    run_op(2'b10, 32'd5, 32'd7, 0, 0);
    run_op(2'b11, 32'd9, 32'd9, 0, 0);
    run_op(2'b11, 32'd3, 32'd5, 0, 0);
    run_op(2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0);
    run_op(2'b01, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0);
    run_op(2'b10, 32'hFFFFFFFF, 32'd1, 0, 0);
    run_op(2'b10, 32'h7FFFFFFF, 32'd1, 0, 0);
    run_op(2'b11, 32'h80000000, 32'd1, 0, 0);
    run_op(2'b10, 32'h12345678, 32'h11111111, 1, 0);

    // abort an ADD at bit index 10
    @(negedge clk);
    Start = 1'b1; Op = 2'b10; DataA = $urandom; DataB = $urandom;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    repeat (10) @(negedge clk);
    check_val("abort_busy_pre", Busy, 1);
    rst = 1'b1;
    #1;
    check_val("abort_busy", Busy, 0);
    check_val("abort_done", Done, 0);
    check_val("abort_result", Result, 0);
    check_val("abort_flags", {CarryOut, Zero}, 0);
    check_val("abort_slice", {SliceSel, SliceA, SliceB, SliceInvertB, SliceCin}, 0);
    @(negedge clk);
    check_val("abort_no_done", Done, 0);
    run_op(2'b10, 32'd1, 32'd1, 0, 1);

    for (int i = 0; i < 20; i++) begin
      rop = 2'($urandom_range(0, 3));
      run_op(rop, $urandom, $urandom, ($urandom_range(0, 3) == 0), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_alu_ctrl.md
SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and result width in bits (minimum 2).
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port Start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port Op  input  2  operation: 00 AND, 01 OR, 10 ADD, 11 SUB.
REQ-006 SHALL have ports DataA, DataB  input  WIDTH  operands, captured on Start acceptance.
REQ-007 SHALL have port SliceSel  output  2  Sel to the 1-bit slice (AND 00, OR 01, ADD/SUB 10).
REQ-008 SHALL have ports SliceA, SliceB, SliceInvertB, SliceCin  output  1 each  slice operand, invert and carry-in drives.
REQ-009 SHALL have ports SliceOut, SliceCout  input  1 each  slice result and carry-out (combinational from slice).
REQ-010 SHALL have port Busy  output  1  high while in RUN.
REQ-011 SHALL have port Done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port Result  output  WIDTH  completed result, held until next acceptance.
REQ-013 SHALL have ports CarryOut, Zero  output  1 each  MSB carry-out, Result==0; held with Result.

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; no other states.
REQ-015 IDLE with Start=1 at an edge SHALL latch DataA, DataB, Op, clear bit index to 0, enter RUN.
REQ-016 RUN SHALL process one bit per cycle, LSB first, bit index 0..WIDTH-1, presenting bit i of the latched operands on SliceA/SliceB combinationally.
REQ-017 SliceInvertB SHALL be 1 only for SUB; SliceSel SHALL be 10 for ADD and SUB.
REQ-018 SliceCin SHALL be SliceInvertB at bit 0 and the registered SliceCout of the previous bit otherwise.
REQ-019 Each RUN edge SHALL store SliceOut into result bit i and SliceCout into the carry register.
REQ-020 After the edge storing bit WIDTH-1, state SHALL be DONE; Done=1 for exactly that one cycle, then IDLE.
REQ-021 Start-edge to Done-high latency SHALL be WIDTH+1 cycles; Busy high for exactly WIDTH cycles.
REQ-022 Result, CarryOut, Zero SHALL update together on entry to DONE and hold until the next DONE or reset.
REQ-023 CarryOut SHALL be final carry for ADD/SUB and 0 for AND/OR.
REQ-024 Start in RUN or DONE SHALL be ignored (not queued); Op/DataA/DataB changes during RUN SHALL have no effect.
REQ-025 Outside RUN, all Slice* outputs SHALL be 0.

Reset
REQ-026 rst high SHALL immediately force IDLE; Busy, Done, Result, CarryOut, Zero, bit index, carry register to 0.
REQ-027 rst asserted mid-RUN SHALL abort the operation with no Done pulse; Start on the first edge after rst release SHALL be accepted.

Configuration
REQ-028 Macro SERIAL_ALU_OVF_EN defined: SHALL add port Overflow output 1, = SliceCin XOR SliceCout at bit WIDTH-1 for ADD/SUB (0 for AND/OR), updated/held/reset like CarryOut.
REQ-029 Macro SERIAL_ALU_OVF_EN undefined: Overflow port and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=32)
REQ-030 ADD 5+7 -> Result 0x0000000C, CarryOut 0, Zero 0, Done exactly 33 cycles after Start edge, single-cycle pulse.
REQ-031 SUB 9-9 -> Result 0, Zero 1, CarryOut 1; SUB 3-5 -> Result 0xFFFFFFFE, CarryOut 0, Zero 0.
REQ-032 AND 0xF0F0F0F0,0xFF00FF00 -> 0xF000F000; OR same operands -> 0xFFF0FFF0; CarryOut 0 both.
REQ-033 Start with new operands held high through RUN -> first result unaffected, no second op until Start re-sampled in IDLE.
REQ-034 rst pulse at bit index 10 of an ADD -> all outputs 0 at once, no Done; subsequent ADD 1+1 -> Result 2.
REQ-035 With SERIAL_ALU_OVF_EN: ADD 0x7FFFFFFF+1 -> Result 0x80000000, Overflow 1, CarryOut 0; ADD 0xFFFFFFFF+1 -> Overflow 0, CarryOut 1.
